// File: rtl/elevator_pkg.sv
// Shared definitions for the elevator request scheduler: command encodings,
// FSM state type and the floor-index width helper.
package elevator_pkg;

  localparam logic [1:0] CMD_IDLE  = 2'b00;
  localparam logic [1:0] CMD_UP    = 2'b01;
  localparam logic [1:0] CMD_DOWN  = 2'b10;
  localparam logic [1:0] CMD_SERVE = 2'b11;

  // State encodings equal the command they drive, so the command output is the state register.
  typedef enum logic [1:0] {
    ST_IDLE      = CMD_IDLE,
    ST_MOVE_UP   = CMD_UP,
    ST_MOVE_DOWN = CMD_DOWN,
    ST_SERVE     = CMD_SERVE
  } elev_state_t;

  // Floor index width; a single-floor building still gets a 1-bit index.
  function automatic int floor_bits(input int n_floors);
    return (n_floors <= 1) ? 1 : $clog2(n_floors);
  endfunction

endpackage

// File: rtl/elevator_req_pick.sv
// SCAN decision function: serve here, otherwise keep going in the current
// direction while requests remain ahead, otherwise reverse, otherwise idle.
// mask_here ignores the current floor's request (used as the floor is being cleared).
module elevator_req_pick
  import elevator_pkg::*;
#(
  parameter int N_FLOORS   = 4,
  parameter int FLOOR_BITS = floor_bits(N_FLOORS)
) (
  input  logic [N_FLOORS-1:0]   pending,
  input  logic [FLOOR_BITS-1:0] cur_floor,
  input  logic                  dir_up,
  input  logic                  mask_here,
  output elev_state_t           next_state,
  output logic                  next_dir_up
);

  logic here;
  logic above;
  logic below;

  // Reduce pending requests relative to the current floor.
  always_comb begin
    above = 1'b0;
    below = 1'b0;
    for (int i = 0; i < N_FLOORS; i++) begin
      if (FLOOR_BITS'(i) > cur_floor) above = above | pending[i];
      if (FLOOR_BITS'(i) < cur_floor) below = below | pending[i];
    end
    here = pending[cur_floor] & ~mask_here;
  end

  // Pick the next state; direction only flips when a reversal is taken.
  always_comb begin
    next_state  = ST_IDLE;
    next_dir_up = dir_up;
    if (here) begin
      next_state = ST_SERVE;
    end else if (dir_up) begin
      if (above) begin
        next_state = ST_MOVE_UP;
      end else if (below) begin
        next_state  = ST_MOVE_DOWN;
        next_dir_up = 1'b0;
      end
    end else begin
      if (below) begin
        next_state = ST_MOVE_DOWN;
      end else if (above) begin
        next_state  = ST_MOVE_UP;
        next_dir_up = 1'b1;
      end
    end
  end

endmodule

// File: rtl/elevator_ctrl.sv
// Elevator request scheduler. Latches floor calls, runs SCAN and drives the
// body's 2-bit command. Optional move watchdog under ELEV_CTRL_WDOG_EN.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | no command; waits for requests and closed doors
// MOVE_UP   | body moving up; re-decide when cur_floor changes
// MOVE_DOWN | body moving down; re-decide when cur_floor changes
// SERVE     | doors cycle at cur_floor; leave on serve_completing
module elevator_ctrl
  import elevator_pkg::*;
#(
  parameter int N_FLOORS    = 4,
  parameter int FLOOR_BITS  = floor_bits(N_FLOORS),
  parameter int WDOG_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_FLOORS-1:0]   req,
  input  logic [FLOOR_BITS-1:0] cur_floor,
  input  logic                  doors_open,
  input  logic                  serve_completing,
  input  logic                  served_pulse,
  output logic [1:0]            command,
  output logic [N_FLOORS-1:0]   pending,
  output logic                  dir_up,
  output logic                  busy,
  output logic                  fault
);

  elev_state_t           state_q, state_n;
  logic                  dir_up_q, dir_up_n;
  logic [N_FLOORS-1:0]   pending_q, pending_n;
  logic [FLOOR_BITS-1:0] start_floor_q, start_floor_n;
  logic [N_FLOORS-1:0]   floor_onehot;
  logic [N_FLOORS-1:0]   clr;
  logic                  arrived;
  logic                  in_move;
  elev_state_t           pick_state;
  logic                  pick_dir_up;

  // The current floor only masks itself when its service is completing.
  elevator_req_pick #(
    .N_FLOORS   (N_FLOORS),
    .FLOOR_BITS (FLOOR_BITS)
  ) u_pick (
    .pending     (pending_q),
    .cur_floor   (cur_floor),
    .dir_up      (dir_up_q),
    .mask_here   (state_q == ST_SERVE),
    .next_state  (pick_state),
    .next_dir_up (pick_dir_up)
  );

  // One-hot of the current floor, used to clear a served request.
  always_comb begin
    floor_onehot            = '0;
    floor_onehot[cur_floor] = 1'b1;
  end

  assign arrived = (cur_floor != start_floor_q);
  assign in_move = (state_q == ST_MOVE_UP) || (state_q == ST_MOVE_DOWN);

`ifdef ELEV_CTRL_WDOG_EN
  localparam int WDOG_BITS = $clog2(WDOG_CYCLES + 1);

  logic [WDOG_BITS-1:0] wdog_q, wdog_n;
  logic                 fault_q, fault_n;
`endif

  // Next-state, direction, floor-clear and watchdog decisions.
  always_comb begin
    state_n       = state_q;
    dir_up_n      = dir_up_q;
    start_floor_n = start_floor_q;
    clr           = '0;
`ifdef ELEV_CTRL_WDOG_EN
    wdog_n        = '0;
    fault_n       = fault_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (!doors_open) begin
          state_n  = pick_state;
          dir_up_n = pick_dir_up;
        end
      end
      ST_MOVE_UP, ST_MOVE_DOWN: begin
        if (arrived) begin
          state_n  = pick_state;
          dir_up_n = pick_dir_up;
        end
      end
      ST_SERVE: begin
        // Leaving on serve_completing lands the new command on the served_pulse edge.
        if (serve_completing) begin
          clr      = floor_onehot;
          state_n  = pick_state;
          dir_up_n = pick_dir_up;
        end else if (served_pulse) begin
          clr     = floor_onehot;
          state_n = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase

`ifdef ELEV_CTRL_WDOG_EN
    // Count stalled move cycles; a stuck body trips a sticky fault.
    if (in_move && !arrived) begin
      if (wdog_q == WDOG_BITS'(WDOG_CYCLES - 1)) begin
        fault_n = 1'b1;
        state_n = ST_IDLE;
      end else begin
        wdog_n = wdog_q + 1'b1;
      end
    end
    if (fault_q) begin
      state_n  = ST_IDLE;
      dir_up_n = dir_up_q;
    end
`endif

    // Record the departure floor on entering a move and on each arrival.
    if (((state_n == ST_MOVE_UP) || (state_n == ST_MOVE_DOWN)) &&
        ((state_n != state_q) || arrived)) begin
      start_floor_n = cur_floor;
    end

    pending_n = (pending_q | req) & ~clr;
  end

  // Controller state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      dir_up_q      <= 1'b1;
      pending_q     <= '0;
      start_floor_q <= '0;
    end else begin
      state_q       <= state_n;
      dir_up_q      <= dir_up_n;
      pending_q     <= pending_n;
      start_floor_q <= start_floor_n;
    end
  end

`ifdef ELEV_CTRL_WDOG_EN
  // Watchdog counter and sticky fault flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdog_q  <= '0;
      fault_q <= 1'b0;
    end else begin
      wdog_q  <= wdog_n;
      fault_q <= fault_n;
    end
  end

  assign fault = fault_q;
`else
  logic unused_wdog_cfg;
  logic unused_in_move;
  assign unused_wdog_cfg = (WDOG_CYCLES == 0);
  assign unused_in_move  = in_move;
  assign fault           = 1'b0;
`endif

  assign command = state_q;
  assign pending = pending_q;
  assign dir_up  = dir_up_q;
  assign busy    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_elevator_ctrl.sv
// Directed testbench for elevator_ctrl; expected values are hand-derived.
// Watchdog scenario changes expectations when ELEV_CTRL_WDOG_EN is defined.
module tb_elevator_ctrl;

  localparam int NF = 4;
  localparam int FB = 2;

  logic          clk;
  logic          rst_n;
  logic [NF-1:0] req;
  logic [FB-1:0] cur_floor;
  logic          doors_open;
  logic          serve_completing;
  logic          served_pulse;
  logic [1:0]    command;
  logic [NF-1:0] pending;
  logic          dir_up;
  logic          busy;
  logic          fault;

  int n_pass;
  int n_total;

  elevator_ctrl #(
    .N_FLOORS    (NF),
    .FLOOR_BITS  (FB),
    .WDOG_CYCLES (16)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .req              (req),
    .cur_floor        (cur_floor),
    .doors_open       (doors_open),
    .serve_completing (serve_completing),
    .served_pulse     (served_pulse),
    .command          (command),
    .pending          (pending),
    .dir_up           (dir_up),
    .busy             (busy),
    .fault            (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req = '0; cur_floor = '0; doors_open = 1'b0;
    serve_completing = 1'b0; served_pulse = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    n_total++; if (command !== 2'b00) $display("FAIL reset_command got=%b exp=00", command); else n_pass++;
    n_total++; if (pending !== 4'b0000) $display("FAIL reset_pending got=%b exp=0000", pending); else n_pass++;
    n_total++; if (dir_up !== 1'b1) $display("FAIL reset_dir_up got=%b exp=1", dir_up); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else n_pass++;
    n_total++; if (fault !== 1'b0) $display("FAIL reset_fault got=%b exp=0", fault); else n_pass++;
    tick();
    n_total++; if (command !== 2'b00) $display("FAIL reset_idle_hold got=%b exp=00", command); else n_pass++;
  endtask

  task automatic test_serve_here();
    cur_floor = 2'd0; req = 4'b0001;
    tick();
    n_total++; if (pending !== 4'b0001) $display("FAIL here_latch pending=%b exp=0001", pending); else n_pass++;
    n_total++; if (command !== 2'b00) $display("FAIL here_e0 command=%b exp=00", command); else n_pass++;
    req = '0;
    tick();
    n_total++; if (command !== 2'b11) $display("FAIL here_e1 command=%b exp=11", command); else n_pass++;
    doors_open = 1'b1;
    tick(); tick();
    n_total++; if (command !== 2'b11) $display("FAIL here_hold command=%b exp=11", command); else n_pass++;
    serve_completing = 1'b1;
    tick();
    serve_completing = 1'b0; served_pulse = 1'b1;
    n_total++; if (command !== 2'b00) $display("FAIL here_done command=%b exp=00", command); else n_pass++;
    n_total++; if (pending !== 4'b0000) $display("FAIL here_clear pending=%b exp=0000", pending); else n_pass++;
    tick();
    served_pulse = 1'b0;
    n_total++; if (command !== 2'b00) $display("FAIL here_after command=%b exp=00", command); else n_pass++;
    doors_open = 1'b0;
    tick();
  endtask

  task automatic test_move_up();
    cur_floor = 2'd0; req = 4'b1000;
    tick();
    req = '0;
    tick();
    n_total++; if (command !== 2'b01) $display("FAIL up_start command=%b exp=01", command); else n_pass++;
    tick(); tick();
    n_total++; if (command !== 2'b01) $display("FAIL up_hold command=%b exp=01", command); else n_pass++;
    cur_floor = 2'd1;
    tick();
    n_total++; if (command !== 2'b01) $display("FAIL up_f1 command=%b exp=01", command); else n_pass++;
    cur_floor = 2'd2;
    tick();
    n_total++; if (command !== 2'b01) $display("FAIL up_f2 command=%b exp=01", command); else n_pass++;
    cur_floor = 2'd3;
    tick();
    n_total++; if (command !== 2'b11) $display("FAIL up_f3 command=%b exp=11", command); else n_pass++;
    doors_open = 1'b1; serve_completing = 1'b1;
    tick();
    serve_completing = 1'b0;
    n_total++; if (command !== 2'b00) $display("FAIL up_idle command=%b exp=00", command); else n_pass++;
    n_total++; if (pending !== 4'b0000) $display("FAIL up_clear pending=%b exp=0000", pending); else n_pass++;
    doors_open = 1'b0;
    tick();
  endtask

  task automatic test_scan_reverse();
    cur_floor = 2'd1; req = 4'b1001;
    tick();
    req = '0;
    tick();
    n_total++; if (command !== 2'b01) $display("FAIL scan_up command=%b exp=01", command); else n_pass++;
    cur_floor = 2'd2;
    tick();
    cur_floor = 2'd3;
    tick();
    n_total++; if (command !== 2'b11) $display("FAIL scan_serve3 command=%b exp=11", command); else n_pass++;
    serve_completing = 1'b1;
    tick();
    serve_completing = 1'b0;
    n_total++; if (command !== 2'b10) $display("FAIL scan_rev command=%b exp=10", command); else n_pass++;
    n_total++; if (dir_up !== 1'b0) $display("FAIL scan_dir dir_up=%b exp=0", dir_up); else n_pass++;
    n_total++; if (pending !== 4'b0001) $display("FAIL scan_pend pending=%b exp=0001", pending); else n_pass++;
    cur_floor = 2'd2;
    tick();
    n_total++; if (command !== 2'b10) $display("FAIL scan_f2 command=%b exp=10", command); else n_pass++;
    cur_floor = 2'd1;
    tick();
    cur_floor = 2'd0;
    tick();
    n_total++; if (command !== 2'b11) $display("FAIL scan_serve0 command=%b exp=11", command); else n_pass++;
    serve_completing = 1'b1;
    tick();
    serve_completing = 1'b0;
    n_total++; if (command !== 2'b00) $display("FAIL scan_idle command=%b exp=00", command); else n_pass++;
    n_total++; if (dir_up !== 1'b0) $display("FAIL scan_dir_keep dir_up=%b exp=0", dir_up); else n_pass++;
  endtask

  task automatic test_coincident_req();
    cur_floor = 2'd2; req = 4'b0100;
    tick();
    req = '0;
    tick();
    n_total++; if (command !== 2'b11) $display("FAIL coin_serve command=%b exp=11", command); else n_pass++;
    req = 4'b0100;
    tick();
    req = '0;
    n_total++; if (pending !== 4'b0100) $display("FAIL coin_absorb pending=%b exp=0100", pending); else n_pass++;
    req = 4'b0101; serve_completing = 1'b1;
    tick();
    req = '0; serve_completing = 1'b0;
    n_total++; if (pending !== 4'b0001) $display("FAIL coin_drop pending=%b exp=0001", pending); else n_pass++;
    n_total++; if (command !== 2'b00) $display("FAIL coin_idle command=%b exp=00", command); else n_pass++;
    tick();
    n_total++; if (command !== 2'b10) $display("FAIL coin_next command=%b exp=10", command); else n_pass++;
  endtask

  task automatic test_reset_mid();
    #2;
    rst_n = 1'b0;
    #1;
    n_total++; if (command !== 2'b00) $display("FAIL rstmid_command got=%b exp=00", command); else n_pass++;
    n_total++; if (pending !== 4'b0000) $display("FAIL rstmid_pending got=%b exp=0000", pending); else n_pass++;
    n_total++; if (dir_up !== 1'b1) $display("FAIL rstmid_dir_up got=%b exp=1", dir_up); else n_pass++;
    do_reset();
  endtask

  task automatic test_recovery();
    cur_floor = 2'd2; req = 4'b0100;
    tick();
    req = '0;
    tick();
    n_total++; if (command !== 2'b11) $display("FAIL recov_serve command=%b exp=11", command); else n_pass++;
    served_pulse = 1'b1;
    tick();
    served_pulse = 1'b0;
    n_total++; if (command !== 2'b00) $display("FAIL recov_idle command=%b exp=00", command); else n_pass++;
    n_total++; if (pending !== 4'b0000) $display("FAIL recov_clear pending=%b exp=0000", pending); else n_pass++;
  endtask

  task automatic test_doors_block();
    cur_floor = 2'd2; doors_open = 1'b1; req = 4'b0001;
    tick();
    req = '0;
    tick(); tick();
    n_total++; if (command !== 2'b00) $display("FAIL doors_hold command=%b exp=00", command); else n_pass++;
    doors_open = 1'b0;
    tick();
    n_total++; if (command !== 2'b10) $display("FAIL doors_go command=%b exp=10", command); else n_pass++;
    n_total++; if (dir_up !== 1'b0) $display("FAIL doors_dir dir_up=%b exp=0", dir_up); else n_pass++;
    do_reset();
  endtask

  task automatic test_watchdog();
    cur_floor = 2'd0; req = 4'b1000;
    tick();
    req = '0;
    tick();
    n_total++; if (command !== 2'b01) $display("FAIL wdog_start command=%b exp=01", command); else n_pass++;
    for (int i = 0; i < 15; i++) tick();
    n_total++; if (command !== 2'b01) $display("FAIL wdog_pre command=%b exp=01", command); else n_pass++;
    n_total++; if (fault !== 1'b0) $display("FAIL wdog_pre_fault fault=%b exp=0", fault); else n_pass++;
    tick();
`ifdef ELEV_CTRL_WDOG_EN
    n_total++; if (fault !== 1'b1) $display("FAIL wdog_fault fault=%b exp=1", fault); else n_pass++;
    n_total++; if (command !== 2'b00) $display("FAIL wdog_idle command=%b exp=00", command); else n_pass++;
    req = 4'b0010;
    tick();
    req = '0;
    n_total++; if (pending !== 4'b1010) $display("FAIL wdog_latch pending=%b exp=1010", pending); else n_pass++;
    tick();
    n_total++; if (command !== 2'b00) $display("FAIL wdog_stuck command=%b exp=00", command); else n_pass++;
    n_total++; if (fault !== 1'b1) $display("FAIL wdog_sticky fault=%b exp=1", fault); else n_pass++;
`else
    n_total++; if (fault !== 1'b0) $display("FAIL nowdog_fault fault=%b exp=0", fault); else n_pass++;
    n_total++; if (command !== 2'b01) $display("FAIL nowdog_hold command=%b exp=01", command); else n_pass++;
`endif
    do_reset();
    n_total++; if (fault !== 1'b0) $display("FAIL wdog_reset fault=%b exp=0", fault); else n_pass++;
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    test_reset();
    test_serve_here();
    test_move_up();
    test_scan_reverse();
    test_coincident_req();
    test_reset_mid();
    test_recovery();
    test_doors_block();
    test_watchdog();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout reached without finishing");
    $fatal(1, "timeout");
  end

endmodule
